// File: rtl/pkg_mpu.sv
// rtl/pkg_mpu.sv - MPU dispatch types and thread-ID width
package pkg_mpu;
  localparam int WIDTH_THID = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    ISSUE  = 2'd2,
    DONE   = 2'd3
  } fsm_dispatch_t;
endpackage

// File: rtl/pkg_top.sv
// rtl/pkg_top.sv - integration-level constants shared across the MPU blocks
package pkg_top;
  localparam int NUM_TPU = 4;
endpackage

// File: rtl/dispatch_mpu_if.sv
// rtl/dispatch_mpu_if.sv - MPU/TPU dispatch bus between the MPU side and the dispatcher
interface dispatch_mpu_if #(
  parameter int NUM_TPU    = pkg_top::NUM_TPU,
  parameter int WIDTH_THID = pkg_mpu::WIDTH_THID
);
  logic                  I_Req_Dispatch;
  logic [WIDTH_THID-1:0] I_ThID;
  logic [NUM_TPU-1:0]    I_En_TPU;
  logic [NUM_TPU-1:0]    I_Ack_TPU;
  logic [NUM_TPU-1:0]    I_Commit_TPU;
  logic [NUM_TPU-1:0]    O_Req_TPU;
  logic [WIDTH_THID-1:0] O_ThID;
  logic                  O_Ack_Dispatch;
  logic                  O_Commit;
  logic [NUM_TPU-1:0]    O_Busy_TPU;
  logic                  O_Full;
  logic [1:0]            O_State;

  modport master (
    output I_Req_Dispatch, I_ThID, I_En_TPU, I_Ack_TPU, I_Commit_TPU,
    input  O_Req_TPU, O_ThID, O_Ack_Dispatch, O_Commit, O_Busy_TPU, O_Full, O_State
  );

  modport slave (
    input  I_Req_Dispatch, I_ThID, I_En_TPU, I_Ack_TPU, I_Commit_TPU,
    output O_Req_TPU, O_ThID, O_Ack_Dispatch, O_Commit, O_Busy_TPU, O_Full, O_State
  );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker: lowest request at or above ptr, else lowest overall
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  logic found;

  // Search upward from the pointer first, then wrap and search from index 0
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dispatch_mpu.sv
// rtl/dispatch_mpu.sv - dispatches MPU thread requests to free TPUs and tracks per-TPU busy state
module dispatch_mpu
  import pkg_mpu::*;
#(
  parameter int NUM_TPU    = pkg_top::NUM_TPU,
  parameter int WIDTH_THID = pkg_mpu::WIDTH_THID
) (
  input logic           clock,
  input logic           reset,
  dispatch_mpu_if.slave bus
);

  localparam int PTR_W = (NUM_TPU > 1) ? $clog2(NUM_TPU) : 1;

  fsm_dispatch_t         state, state_n;
  logic [WIDTH_THID-1:0] thid_q, thid_n;
  logic [NUM_TPU-1:0]    grant_q, grant_n;
  logic [NUM_TPU-1:0]    busy_q, busy_n;
  logic [NUM_TPU-1:0]    set_mask;
  logic [NUM_TPU-1:0]    free;
  logic [NUM_TPU-1:0]    arb_grant;
  logic [NUM_TPU-1:0]    req_tpu;
  logic [PTR_W-1:0]      ptr_q, ptr_n;
  logic [PTR_W-1:0]      ptr_after_grant;
  logic                  commit_q, commit_n;

  // A TPU is a candidate only while enabled and not running a thread
  assign free = bus.I_En_TPU & ~busy_q;

  rr_arbiter #(
    .N     (NUM_TPU),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req   (free),
    .ptr   (ptr_q),
    .grant (arb_grant)
  );

  // Pointer moves one past the granted TPU so the next search starts after it
  always_comb begin
    ptr_after_grant = '0;
    for (int i = 0; i < NUM_TPU; i++) begin
      if (grant_q[i]) begin
        ptr_after_grant = (i == NUM_TPU - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  // Next-state logic: capture, select, issue (with enable-loss abort), done
  always_comb begin
    state_n  = state;
    thid_n   = thid_q;
    grant_n  = grant_q;
    ptr_n    = ptr_q;
    set_mask = '0;
    case (state)
      IDLE: begin
        if (bus.I_Req_Dispatch) begin
          thid_n  = bus.I_ThID;
          state_n = SELECT;
        end
      end
      SELECT: begin
        if (free != '0) begin
          grant_n = arb_grant;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        // Losing the enable wins over an ack arriving in the same cycle
        if ((bus.I_En_TPU & grant_q) == '0) begin
          grant_n = '0;
          state_n = SELECT;
        end else if ((bus.I_Ack_TPU & grant_q) != '0) begin
          set_mask = grant_q;
          ptr_n    = ptr_after_grant;
          grant_n  = '0;
          state_n  = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Commits clear their bits and a new grant sets its bit, all in the same cycle
  always_comb begin
    busy_n   = (busy_q & ~bus.I_Commit_TPU) | set_mask;
    commit_n = (busy_q != '0) && (busy_n == '0);
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      thid_q   <= '0;
      grant_q  <= '0;
      busy_q   <= '0;
      ptr_q    <= '0;
      commit_q <= 1'b0;
    end else begin
      state    <= state_n;
      thid_q   <= thid_n;
      grant_q  <= grant_n;
      busy_q   <= busy_n;
      ptr_q    <= ptr_n;
      commit_q <= commit_n;
    end
  end

  assign req_tpu            = (state == ISSUE) ? grant_q : '0;
  assign bus.O_Req_TPU      = req_tpu;
  assign bus.O_ThID         = (req_tpu != '0) ? thid_q : '0;
  assign bus.O_Ack_Dispatch = (state == DONE);
  assign bus.O_Commit       = commit_q;
  assign bus.O_Busy_TPU     = busy_q;
  assign bus.O_Full         = (state == SELECT) && (free == '0);
  assign bus.O_State        = state;

endmodule

// File: tb/tb_dispatch_mpu.sv
// tb/tb_dispatch_mpu.sv - cycle-by-cycle vector table plus reset-in-ISSUE sequence for dispatch_mpu
module tb_dispatch_mpu;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  dispatch_mpu_if bus ();

  dispatch_mpu dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       req;
    logic [7:0] thid;
    logic [3:0] en;
    logic [3:0] ack;
    logic [3:0] cmt;
    logic [1:0] st;
    logic [3:0] rq;
    logic [7:0] th;
    logic       ad;
    logic       cm;
    logic [3:0] busy;
    logic       full;
  } vec_t;

  vec_t vecs[$];

  function automatic void v(input int req, input int thid, input int en, input int ack, input int cmt,
                            input int st, input int rq, input int th, input int ad, input int cm,
                            input int busy, input int full);
    vec_t x;
    x.req  = 1'(req);
    x.thid = 8'(thid);
    x.en   = 4'(en);
    x.ack  = 4'(ack);
    x.cmt  = 4'(cmt);
    x.st   = 2'(st);
    x.rq   = 4'(rq);
    x.th   = 8'(th);
    x.ad   = 1'(ad);
    x.cm   = 1'(cm);
    x.busy = 4'(busy);
    x.full = 1'(full);
    vecs.push_back(x);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic drive(input int req, input int thid, input int en, input int ack, input int cmt);
    bus.I_Req_Dispatch = 1'(req);
    bus.I_ThID         = 8'(thid);
    bus.I_En_TPU       = 4'(en);
    bus.I_Ack_TPU      = 4'(ack);
    bus.I_Commit_TPU   = 4'(cmt);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int n;
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    drive(0, 0, 0, 0, 0);

    //  req thid en  ack cmt | st rq th ad cm busy full
    v(0,  0, 15, 0,  0,   0, 0,  0, 0, 0,  0, 0);
    v(1,  5, 15, 0,  0,   0, 0,  0, 0, 0,  0, 0);
    v(0,  0, 15, 0,  0,   1, 0,  0, 0, 0,  0, 0);
    v(0,  0, 15, 1,  0,   2, 1,  5, 0, 0,  0, 0);
    v(0,  0, 15, 0,  0,   3, 0,  0, 1, 0,  1, 0);
    v(1,  6, 15, 0,  0,   0, 0,  0, 0, 0,  1, 0);
    v(0,  0, 15, 0,  0,   1, 0,  0, 0, 0,  1, 0);
    v(0,  0, 15, 2,  0,   2, 2,  6, 0, 0,  1, 0);
    v(0,  0, 15, 0,  0,   3, 0,  0, 1, 0,  3, 0);
    v(1,  7, 15, 0,  0,   0, 0,  0, 0, 0,  3, 0);
    v(0,  0, 15, 0,  0,   1, 0,  0, 0, 0,  3, 0);
    v(0,  0, 15, 4,  0,   2, 4,  7, 0, 0,  3, 0);
    v(0,  0, 15, 0,  0,   3, 0,  0, 1, 0,  7, 0);
    v(1,  8, 15, 0,  2,   0, 0,  0, 0, 0,  7, 0);
    v(0,  0, 15, 0,  0,   1, 0,  0, 0, 0,  5, 0);
    v(0,  0, 15, 1,  0,   2, 8,  8, 0, 0,  5, 0);
    v(0,  0, 15, 8,  4,   2, 8,  8, 0, 0,  5, 0);
    v(0,  0, 15, 0,  0,   3, 0,  0, 1, 0,  9, 0);
    v(1,  9, 15, 0,  0,   0, 0,  0, 0, 0,  9, 0);
    v(0,  0, 15, 0,  0,   1, 0,  0, 0, 0,  9, 0);
    v(0,  0, 15, 2,  0,   2, 2,  9, 0, 0,  9, 0);
    v(0,  0, 15, 0,  0,   3, 0,  0, 1, 0, 11, 0);
    v(0,  0, 15, 0,  8,   0, 0,  0, 0, 0, 11, 0);
    v(0,  0, 15, 0,  0,   0, 0,  0, 0, 0,  3, 0);
    v(0,  0, 15, 0,  3,   0, 0,  0, 0, 0,  3, 0);
    v(0,  0, 15, 0,  0,   0, 0,  0, 0, 1,  0, 0);
    v(1, 10,  3, 0,  0,   0, 0,  0, 0, 0,  0, 0);
    v(0,  0,  3, 0,  0,   1, 0,  0, 0, 0,  0, 0);
    v(0,  0,  3, 1,  0,   2, 1, 10, 0, 0,  0, 0);
    v(0,  0,  3, 0,  0,   3, 0,  0, 1, 0,  1, 0);
    v(1, 11,  3, 0,  0,   0, 0,  0, 0, 0,  1, 0);
    v(0,  0,  3, 0,  0,   1, 0,  0, 0, 0,  1, 0);
    v(0,  0,  3, 2,  0,   2, 2, 11, 0, 0,  1, 0);
    v(0,  0,  3, 0,  0,   3, 0,  0, 1, 0,  3, 0);
    v(1, 12,  3, 0,  0,   0, 0,  0, 0, 0,  3, 0);
    v(0,  0,  3, 0,  0,   1, 0,  0, 0, 0,  3, 1);
    v(0,  0,  3, 0,  1,   1, 0,  0, 0, 0,  3, 1);
    v(0,  0,  3, 0,  0,   1, 0,  0, 0, 0,  2, 0);
    v(0,  0,  3, 1,  0,   2, 1, 12, 0, 0,  2, 0);
    v(0,  0,  3, 0,  0,   3, 0,  0, 1, 0,  3, 0);
    v(1, 13, 15, 0,  0,   0, 0,  0, 0, 0,  3, 0);
    v(1, 77, 15, 0,  0,   1, 0,  0, 0, 0,  3, 0);
    v(1, 99, 15, 0,  0,   2, 4, 13, 0, 0,  3, 0);
    v(0,  0, 11, 4,  0,   2, 4, 13, 0, 0,  3, 0);
    v(0,  0, 11, 0,  0,   1, 0,  0, 0, 0,  3, 0);
    v(0,  0, 11, 8,  0,   2, 8, 13, 0, 0,  3, 0);
    v(1, 55, 11, 0,  0,   3, 0,  0, 1, 0, 11, 0);
    v(0,  0,  0, 0,  0,   0, 0,  0, 0, 0, 11, 0);
    v(0,  0,  0, 0,  0,   0, 0,  0, 0, 0, 11, 0);
    v(0,  0,  0, 0, 11,   0, 0,  0, 0, 0, 11, 0);
    v(0,  0, 15, 0,  0,   0, 0,  0, 0, 1,  0, 0);
    v(0,  0, 15, 0,  0,   0, 0,  0, 0, 0,  0, 0);

    repeat (3) tick();
    reset = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      drive(int'(vecs[k].req), int'(vecs[k].thid), int'(vecs[k].en), int'(vecs[k].ack), int'(vecs[k].cmt));
      chk($sformatf("r%0d.state", k), 32'(bus.O_State), 32'(vecs[k].st));
      chk($sformatf("r%0d.req_tpu", k), 32'(bus.O_Req_TPU), 32'(vecs[k].rq));
      chk($sformatf("r%0d.thid", k), 32'(bus.O_ThID), 32'(vecs[k].th));
      chk($sformatf("r%0d.ack_dispatch", k), 32'(bus.O_Ack_Dispatch), 32'(vecs[k].ad));
      chk($sformatf("r%0d.commit", k), 32'(bus.O_Commit), 32'(vecs[k].cm));
      chk($sformatf("r%0d.busy", k), 32'(bus.O_Busy_TPU), 32'(vecs[k].busy));
      chk($sformatf("r%0d.full", k), 32'(bus.O_Full), 32'(vecs[k].full));
      tick();
    end

    // Warm-up dispatch so busy and pointer are nonzero before the reset test
    drive(1, 21, 15, 0, 0);
    tick();
    drive(0, 0, 15, 0, 0);
    n = 0;
    while (bus.O_Req_TPU == 4'd0 && n < 8) begin
      tick();
      #1;
      n++;
    end
    chk("s1.req_wait", 32'(bus.O_Req_TPU != 4'd0), 32'd1);
    chk("s1.req_tpu", 32'(bus.O_Req_TPU), 32'd1);
    chk("s1.thid", 32'(bus.O_ThID), 32'd21);
    drive(0, 0, 15, 1, 0);
    tick();
    drive(0, 0, 15, 0, 0);
    chk("s1.ack_dispatch", 32'(bus.O_Ack_Dispatch), 32'd1);
    chk("s1.busy", 32'(bus.O_Busy_TPU), 32'd1);
    tick();

    // Reset held for two cycles while a grant is outstanding in ISSUE
    drive(1, 22, 15, 0, 0);
    tick();
    drive(0, 0, 15, 0, 0);
    tick();
    drive(0, 0, 15, 0, 0);
    chk("s2.state_issue", 32'(bus.O_State), 32'd2);
    chk("s2.req_tpu", 32'(bus.O_Req_TPU), 32'd2);
    reset = 1'b0;
    drive(0, 0, 15, 2, 0);
    for (int c = 0; c < 2; c++) begin
      tick();
      #1;
      chk($sformatf("s2.rst%0d.state", c), 32'(bus.O_State), 32'd0);
      chk($sformatf("s2.rst%0d.req_tpu", c), 32'(bus.O_Req_TPU), 32'd0);
      chk($sformatf("s2.rst%0d.busy", c), 32'(bus.O_Busy_TPU), 32'd0);
      chk($sformatf("s2.rst%0d.ack_dispatch", c), 32'(bus.O_Ack_Dispatch), 32'd0);
      chk($sformatf("s2.rst%0d.thid", c), 32'(bus.O_ThID), 32'd0);
    end
    reset = 1'b1;
    drive(0, 0, 15, 0, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      #1;
      chk($sformatf("s2.post%0d.ack_dispatch", c), 32'(bus.O_Ack_Dispatch), 32'd0);
      chk($sformatf("s2.post%0d.state", c), 32'(bus.O_State), 32'd0);
    end

    // After reset the pointer is back at 0, so TPU0 is chosen again
    drive(1, 23, 15, 0, 0);
    tick();
    drive(0, 0, 15, 0, 0);
    tick();
    drive(0, 0, 15, 0, 0);
    chk("s3.req_tpu", 32'(bus.O_Req_TPU), 32'd1);
    chk("s3.thid", 32'(bus.O_ThID), 32'd23);
    drive(0, 0, 15, 1, 0);
    tick();
    drive(0, 0, 15, 0, 0);
    chk("s3.ack_dispatch", 32'(bus.O_Ack_Dispatch), 32'd1);
    chk("s3.busy", 32'(bus.O_Busy_TPU), 32'd1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dispatch_mpu.md
DISPATCH_MPU -- requirements
Module: dispatch_mpu

Interface
REQ-001 Parameter NUM_TPU, default 4: number of TPUs (pkg_top value at integration).
REQ-002 Parameter WIDTH_THID, default 8: thread ID width.
REQ-003 clock  in  1  single clock; all logic rising-edge.
REQ-004 reset  in  1  synchronous, active-low reset (reset==0 resets on the next rising edge).
REQ-005 I_Req_Dispatch  in  1  dispatch request pulse from the MPU interface.
REQ-006 I_ThID  in  WIDTH_THID  thread ID, valid with I_Req_Dispatch.
REQ-007 I_En_TPU  in  NUM_TPU  TPU enable mask.
REQ-008 O_Req_TPU  out  NUM_TPU  one-hot dispatch request to the selected TPU.
REQ-009 O_ThID  out  WIDTH_THID  captured thread ID; zero when O_Req_TPU==0.
REQ-010 I_Ack_TPU  in  NUM_TPU  per-TPU dispatch acknowledge.
REQ-011 I_Commit_TPU  in  NUM_TPU  per-TPU thread-completion pulse.
REQ-012 O_Ack_Dispatch  out  1  one-cycle dispatch-complete pulse to the MPU interface.
REQ-013 O_Commit  out  1  one-cycle pulse when the last busy TPU commits.
REQ-014 O_Busy_TPU  out  NUM_TPU  per-TPU busy flags.
REQ-015 O_Full  out  1  high in SELECT when no enabled TPU is free.
REQ-016 O_State  out  2  FSM state encoding.

Function
REQ-017 FSM states SHALL be IDLE=0, SELECT=1, ISSUE=2, DONE=3, driven on O_State.
REQ-018 IDLE: on I_Req_Dispatch, capture I_ThID and go to SELECT. I_Req_Dispatch in any other state is ignored.
REQ-019 SELECT: free = I_En_TPU & ~Busy. If free!=0, register a one-hot grant and go to ISSUE. Otherwise stay in SELECT with O_Full=1.
REQ-020 Grant selection: the lowest free index >= RR pointer. If none, wrap to the lowest free index >= 0.
REQ-021 ISSUE: O_Req_TPU = grant and O_ThID = captured ID, both held until acknowledge or abort.
REQ-022 ISSUE acknowledge: when (I_Ack_TPU & grant)!=0, set Busy[g], set RR pointer = g+1 (wraps from NUM_TPU-1 to 0), and go to DONE.
REQ-023 ISSUE abort: if I_En_TPU[g] deasserts before acknowledge, clear the grant, drop O_Req_TPU the next cycle, and return to SELECT. Abort has priority over a same-cycle ack.
REQ-024 Acks on non-granted bits SHALL be ignored.
REQ-025 DONE: O_Ack_Dispatch=1 for exactly one cycle, then go to IDLE.
REQ-026 Minimum latency: request at cycle 0, O_Req_TPU at cycle 2, ack at cycle 2, O_Ack_Dispatch at cycle 3.
REQ-027 Commit: I_Commit_TPU[i] clears Busy[i]. A commit on a non-busy TPU is ignored.
REQ-028 Simultaneous commits on multiple TPUs SHALL all apply in the same cycle.
REQ-029 A same-cycle set on a TPU and commit on a different TPU SHALL both apply.
REQ-030 O_Commit = registered (Busy!=0 & next Busy==0 due to commits): one pulse, one cycle later.
REQ-031 Busy of a TPU whose enable deasserts SHALL remain until that TPU commits.

Reset
REQ-032 While reset==0 at a clock edge: FSM=IDLE, Busy=0, RR pointer=0, grant=0, captured ID=0.
REQ-033 During reset, all outputs SHALL be 0 from the next cycle. A reset in any state, including ISSUE, SHALL abandon the dispatch with no ack.

Structure
REQ-034 The pkg_mpu package SHALL hold the fsm_dispatch_t enum and the WIDTH_THID constant. NUM_TPU SHALL come from pkg_top.
REQ-035 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: request vector and pointer; output: one-hot grant), purely combinational. The dispatch_mpu module registers its output.
REQ-036 The RR pointer width SHALL be $clog2(NUM_TPU).

Verification (NUM_TPU=4)
REQ-037 Hold reset=0 for 2 cycles during ISSUE -> O_Req_TPU=0, O_State=0, O_Busy_TPU=0, no O_Ack_Dispatch.
REQ-038 I_En_TPU=1111; request ThID 5, 6, 7 with immediate acks -> grants 0001, 0010, 0100; O_ThID 5, 6, 7; O_Busy_TPU=0111; each O_Ack_Dispatch 3 cycles after its request.
REQ-039 From REQ-038 (pointer=3): commit TPU1; request -> grant 1000. Next request -> wraps to grant 0010.
REQ-040 I_En_TPU=0011, Busy=0011; request -> SELECT, O_Full=1; commit TPU0 -> next cycle grant 0001, O_Full=0.
REQ-041 Busy=0011; I_Commit_TPU=0011 in one cycle -> O_Busy_TPU=0000 and a single O_Commit pulse.
REQ-042 Grant 0100 in ISSUE; clear I_En_TPU[2] before ack -> back to SELECT, then grant 1000 (if free); no O_Ack_Dispatch until the ack.
